// File: rtl/align_pkg.sv
// align_pkg: shared state encoding, parcel width and RVC test for the instruction aligner.
package align_pkg;
    localparam int PARCEL_W = 16;

    typedef enum logic [1:0] {ALIGNED, HALF, SKIP} align_state_e;

    function automatic logic is_rvc(input logic [PARCEL_W-1:0] p);
        return p[1:0] != 2'b11;
    endfunction
endpackage

// File: rtl/inst_align_perf.sv
// inst_align_perf: saturating counters of issued compressed and 32-bit instructions.
module inst_align_perf #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              compressed,
    output logic [PERF_W-1:0] rvc_cnt,
    output logic [PERF_W-1:0] rvi_cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvc_cnt <= '0;
            rvi_cnt <= '0;
        end else begin
            if (load & compressed & ~&rvc_cnt) rvc_cnt <= rvc_cnt + 1'b1;
            if (load & !compressed & ~&rvi_cnt) rvi_cnt <= rvi_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/inst_align.sv
// inst_align: splits/joins 16-bit parcels of fetch words into whole instructions for decode.
// Define INST_ALIGN_PERF_EN to add the perf_rvc_cnt/perf_rvi_cnt issue counters.
module inst_align
    import align_pkg::*;
#(
    parameter int XLEN = 64
`ifdef INST_ALIGN_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [XLEN-1:0]   flush_pc,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [31:0]       f_data,
    input  logic [XLEN-1:0]   f_pc,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [31:0]       d_inst,
    output logic [XLEN-1:0]   d_pc,
    output logic              d_compressed
`ifdef INST_ALIGN_PERF_EN
  , output logic [PERF_W-1:0] perf_rvc_cnt,
    output logic [PERF_W-1:0] perf_rvi_cnt
`endif
);
    align_state_e          state;
    logic [PARCEL_W-1:0]   hold_q;
    logic [XLEN-1:0]       hold_pc_q;
    logic                  out_free, hold_rvc, lo_rvc, fire, emit, e_c;
    logic [31:0]           e_inst;
    logic [XLEN-1:0]       e_pc;
    logic                  unused_flush_pc;

    // Only the halfword bit of the redirect target matters here.
    assign unused_flush_pc = ^{flush_pc[XLEN-1:2], flush_pc[0]};

    assign out_free = !d_valid | d_ready;
    assign hold_rvc = is_rvc(hold_q);
    assign lo_rvc   = is_rvc(f_data[15:0]);
    assign f_ready  = !flush & ((state == SKIP) | (state == ALIGNED & out_free) |
                                (state == HALF & !hold_rvc & out_free));
    assign fire     = f_valid & f_ready;
    assign emit     = !flush & out_free &
                      ((state == ALIGNED & f_valid) | (state == HALF & (hold_rvc | f_valid)));

    always_comb begin
        e_pc   = state == ALIGNED ? f_pc : hold_pc_q;
        e_c    = state == ALIGNED ? lo_rvc : hold_rvc;
        e_inst = state == ALIGNED ? (lo_rvc ? {16'b0, f_data[15:0]} : f_data)
                                  : (hold_rvc ? {16'b0, hold_q} : {f_data[15:0], hold_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ALIGNED;
            hold_q       <= '0;
            hold_pc_q    <= '0;
            d_valid      <= 1'b0;
            d_inst       <= '0;
            d_pc         <= '0;
            d_compressed <= 1'b0;
        end else if (flush) begin
            state     <= flush_pc[1] ? SKIP : ALIGNED;
            hold_q    <= '0;
            hold_pc_q <= '0;
            d_valid   <= 1'b0;
        end else begin
            if (emit) begin
                d_valid      <= 1'b1;
                d_inst       <= e_inst;
                d_pc         <= e_pc;
                d_compressed <= e_c;
            end else if (d_ready) begin
                d_valid <= 1'b0;
            end
            // A whole 32-bit word in ALIGNED leaves nothing behind to hold.
            if (fire & !(state == ALIGNED & !lo_rvc)) begin
                hold_q    <= f_data[31:16];
                hold_pc_q <= f_pc + XLEN'(2);
            end
            if (state == SKIP & fire) state <= HALF;
            else if (state == ALIGNED & fire & lo_rvc) state <= HALF;
            else if (state == HALF & emit & hold_rvc) state <= ALIGNED;
        end
    end

`ifdef INST_ALIGN_PERF_EN
    inst_align_perf #(.PERF_W(PERF_W)) u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (emit),
        .compressed (e_c),
        .rvc_cnt    (perf_rvc_cnt),
        .rvi_cnt    (perf_rvi_cnt)
    );
`endif
endmodule
